// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, fetch FSM states and the NOP encoding.
// The Control_Unit imports the same package, so both agree on the instruction layout.
package cpu_pkg;

   localparam int WORD_SIZE   = 32;
   localparam int OPCODE_SIZE = 5;
   localparam int PC_WIDTH    = 9;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      FETCH      = 2'd1,
      WAIT_SPACE = 2'd2,
      DROP       = 2'd3
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry prefetch FIFO holding {pc, word} pairs; head is read straight from the
// registered storage, so a push becomes visible one cycle later.
module fetch_buffer #(
   parameter int word_size = 32,
   parameter int pc_width  = 9
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [pc_width-1:0]  push_pc,
   input  logic [word_size-1:0] push_word,
   input  logic                 pop,
   input  logic                 flush,
   output logic                 full,
   output logic                 empty,
   output logic [pc_width-1:0]  head_pc,
   output logic [word_size-1:0] head_word
);

   logic [pc_width-1:0]  pc_mem   [2];
   logic [word_size-1:0] word_mem [2];
   logic                 wr_ptr_reg;
   logic                 rd_ptr_reg;
   logic [1:0]           count_reg;
   logic                 do_push;
   logic                 do_pop;

   assign empty   = (count_reg == 2'd0);
   assign full    = (count_reg == 2'd2);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else if (flush) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
         if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 2'd1;
            2'b01:   count_reg <= count_reg - 2'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Storage carries no reset; consumers qualify the head with empty.
   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         pc_mem[wr_ptr_reg]   <= push_pc;
         word_mem[wr_ptr_reg] <= push_word;
      end
   end

   assign head_pc   = pc_mem[rd_ptr_reg];
   assign head_word = word_mem[rd_ptr_reg];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: PC, single-outstanding imem req/ack, 2-deep prefetch buffer,
// stall back-pressure and redirect flush with in-flight response dropping.
module instruction_fetch_unit
   import cpu_pkg::*;
#(
   parameter int                     word_size   = cpu_pkg::WORD_SIZE,
   parameter int                     opcode_size = cpu_pkg::OPCODE_SIZE,
   parameter int                     pc_width    = cpu_pkg::PC_WIDTH,
   parameter logic [pc_width-1:0]    reset_pc    = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 imem_req,
   output logic [pc_width-1:0]  imem_addr,
   input  logic                 imem_ack,
   input  logic [word_size-1:0] imem_rdata,
   input  logic                 stall,
   input  logic                 redirect,
   input  logic [pc_width-1:0]  redirect_pc,
   output logic [word_size-1:0] instruction,
   output logic                 instr_valid,
   output logic [pc_width-1:0]  instr_pc
);

   fetch_state_t         state_reg;
   logic                 req_reg;
   logic [pc_width-1:0]  pc_reg;
   logic [pc_width-1:0]  target_reg;

   logic                 fifo_full;
   logic                 fifo_empty;
   logic [pc_width-1:0]  head_pc;
   logic [word_size-1:0] head_word;
   logic [opcode_size-1:0]           head_opcode;
   logic [word_size-opcode_size-1:0] head_operands;

   logic                 push;
   logic                 pop;
   logic                 fill;

   assign instr_valid = !fifo_empty;
   assign pop         = instr_valid && !stall && !redirect;
   assign push        = (state_reg == FETCH) && imem_ack && !redirect && !fifo_full;
   // Post-push occupancy reaches two only when one entry is already held and none leaves.
   assign fill        = push && !pop && !fifo_empty;

   fetch_buffer #(
      .word_size (word_size),
      .pc_width  (pc_width)
   ) u_fetch_buffer (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_pc   (pc_reg),
      .push_word (imem_rdata),
      .pop       (pop),
      .flush     (redirect),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head_pc   (head_pc),
      .head_word (head_word)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg  <= IDLE;
         req_reg    <= 1'b0;
         pc_reg     <= reset_pc;
         target_reg <= reset_pc;
      end else begin
         case (state_reg)
            IDLE: begin
               state_reg <= FETCH;
               req_reg   <= 1'b1;
               if (redirect) pc_reg <= redirect_pc;
            end
            FETCH: begin
               if (redirect) begin
                  if (imem_ack) begin
                     pc_reg <= redirect_pc;
                  end else begin
                     // Request is committed on the bus; keep it and park the new path.
                     target_reg <= redirect_pc;
                     state_reg  <= DROP;
                  end
               end else if (imem_ack) begin
                  pc_reg <= pc_reg + 1'b1;
                  if (fill) begin
                     state_reg <= WAIT_SPACE;
                     req_reg   <= 1'b0;
                  end
               end
            end
            WAIT_SPACE: begin
               if (redirect) begin
                  pc_reg    <= redirect_pc;
                  state_reg <= FETCH;
                  req_reg   <= 1'b1;
               end else if (pop) begin
                  state_reg <= FETCH;
                  req_reg   <= 1'b1;
               end
            end
            DROP: begin
               if (imem_ack) begin
                  pc_reg    <= redirect ? redirect_pc : target_reg;
                  state_reg <= FETCH;
               end else if (redirect) begin
                  target_reg <= redirect_pc;
               end
            end
            default: begin
               state_reg <= IDLE;
               req_reg   <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req  = req_reg;
   assign imem_addr = pc_reg;

   assign {head_opcode, head_operands} = head_word;
   assign instruction = fifo_empty ? word_size'(NOP_INSTR) : {head_opcode, head_operands};
   assign instr_pc    = fifo_empty ? '0 : head_pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed + randomized bench for instruction_fetch_unit against a stream-level model:
// presented instructions must be consecutive PCs from the last redirect, words from memory.
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req;
   logic [8:0]  imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [8:0]  redirect_pc = 9'h0;
   logic [31:0] instruction;
   logic        instr_valid;
   logic [8:0]  instr_pc;

   logic [31:0] imem [512];
   int          checks = 0;
   int          errors = 0;
   logic [8:0]  exp_pc = 9'h0;
   bit          pending = 1'b0;
   bit          drop_pending = 1'b0;
   int          wait_cnt = 0;
   int          lat_sel = 0;
   logic [8:0]  popped [$];

   instruction_fetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instruction (instruction),
      .instr_valid (instr_valid),
      .instr_pc    (instr_pc)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive memory response and model bookkeeping, clock, then check.
   task automatic cycle();
      logic       was_req, was_ack, acc, redir;
      logic [8:0] was_addr;
      if (imem_req) begin
         if (!pending) begin
            pending  = 1'b1;
            wait_cnt = lat_sel;
         end
         if (wait_cnt == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = imem[imem_addr];
            pending    = 1'b0;
         end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            wait_cnt--;
         end
      end else begin
         imem_ack   = 1'b0;
         imem_rdata = $urandom;
      end

      if (instr_valid) begin
         chk("head_pc", 32'(instr_pc), 32'(exp_pc));
         chk("head_word", instruction, imem[instr_pc]);
      end else begin
         chk("empty_word", instruction, 32'h0);
         chk("empty_pc", 32'(instr_pc), 32'h0);
      end

      redir    = redirect;
      acc      = imem_req && imem_ack && !redirect && !drop_pending;
      was_req  = imem_req;
      was_ack  = imem_ack;
      was_addr = imem_addr;
      if (redirect) begin
         exp_pc       = redirect_pc;
         drop_pending = imem_req && !imem_ack;
      end else begin
         if (imem_ack) drop_pending = 1'b0;
         if (instr_valid && !stall) begin
            popped.push_back(instr_pc);
            exp_pc++;
         end
      end

      @(posedge clk);
      #1;
      redirect = 1'b0;
      if (was_req && !was_ack) begin
         chk("req_held", 32'(imem_req), 32'h1);
         chk("addr_held", 32'(imem_addr), 32'(was_addr));
      end
      if (redir) chk("valid_after_redirect", 32'(instr_valid), 32'h0);
      if (acc)   chk("valid_after_ack", 32'(instr_valid), 32'h1);
   endtask

   initial begin
      bit got;
      int acks;
      int pops;
      for (int i = 0; i < 512; i++) begin
         logic [8:0] a;
         a = 9'(i);
         imem[i] = {a[4:0] ^ 5'h15, a, ~a, a ^ 9'h0A5};
      end
      imem[0] = 32'b10011_000000000_000000001_000000000;
      imem[1] = 32'b00110_000000000_000000001_000000010;

      // Reset values and first request
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", 32'(imem_req), 32'h0);
      chk("rst_addr", 32'(imem_addr), 32'h0);
      chk("rst_valid", 32'(instr_valid), 32'h0);
      chk("rst_instr", instruction, 32'h0);
      chk("rst_pc", 32'(instr_pc), 32'h0);
      rst = 1'b1;
      #1;
      chk("req_at_release", 32'(imem_req), 32'h0);
      cycle();
      chk("first_req", 32'(imem_req), 32'h1);
      chk("first_addr", 32'(imem_addr), 32'h0);

      // Zero-wait streaming: one instruction per cycle
      cycle();
      for (int i = 0; i < 3; i++) begin
         chk("stream_valid", 32'(instr_valid), 32'h1);
         chk("stream_pc", 32'(instr_pc), 32'(i));
         cycle();
      end

      // Asynchronous reset with a pending request
      lat_sel = 3;
      repeat (3) cycle();
      chk("pending_before_reset", 32'(imem_req), 32'h1);
      rst = 1'b0;
      #1;
      chk("midrst_req", 32'(imem_req), 32'h0);
      chk("midrst_addr", 32'(imem_addr), 32'h0);
      chk("midrst_valid", 32'(instr_valid), 32'h0);
      chk("midrst_instr", instruction, 32'h0);
      chk("midrst_pc", 32'(instr_pc), 32'h0);
      pending = 1'b0;
      drop_pending = 1'b0;
      exp_pc = 9'h0;
      imem_ack = 1'b0;
      popped.delete();
      stall = 1'b1;
      lat_sel = 0;
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Stall fills the buffer and stops requests
      repeat (5) cycle();
      chk("stall_req_low", 32'(imem_req), 32'h0);
      chk("stall_valid", 32'(instr_valid), 32'h1);
      chk("stall_head_pc", 32'(instr_pc), 32'h0);
      stall = 1'b0;
      for (int i = 0; i < 20 && popped.size() < 3; i++) cycle();
      chk("unstall_pops", 32'(popped.size()), 32'h3);
      for (int k = 0; k < 3; k++)
         chk("unstall_order", (popped.size() > k) ? 32'(popped[k]) : 32'hFFFF, 32'(k));

      // Three-cycle ack latency
      lat_sel = 3;
      acks = 0;
      repeat (16) begin
         cycle();
         if (imem_ack) acks++;
      end
      chk("lat3_acks", 32'(acks >= 3 && acks <= 4), 32'h1);

      // Redirect while request to 0x05 is pending
      stall = 1'b1;
      lat_sel = 0;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         cycle();
         got = !imem_req && instr_valid;
      end
      chk("reach_wait_space", 32'(got), 32'h1);
      lat_sel = 5;
      redirect = 1'b1;
      redirect_pc = 9'h005;
      cycle();
      chk("redir5_req", 32'(imem_req), 32'h1);
      chk("redir5_addr", 32'(imem_addr), 32'h005);
      stall = 1'b0;
      cycle();
      redirect = 1'b1;
      redirect_pc = 9'h040;
      cycle();
      chk("drop_req", 32'(imem_req), 32'h1);
      chk("drop_old_addr", 32'(imem_addr), 32'h005);
      lat_sel = 0;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         cycle();
         got = imem_ack;
      end
      chk("drop_ack_seen", 32'(got), 32'h1);
      chk("drop_discarded", 32'(instr_valid), 32'h0);
      chk("after_drop_addr", 32'(imem_addr), 32'h040);
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         cycle();
         got = instr_valid;
      end
      chk("first_new_pc", 32'(instr_pc), 32'h040);

      // Redirect in the same cycle as an ack
      cycle();
      redirect = 1'b1;
      redirect_pc = 9'h080;
      cycle();
      chk("same_cycle_ack", 32'(imem_ack), 32'h1);
      chk("same_cycle_addr", 32'(imem_addr), 32'h080);
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         cycle();
         got = instr_valid;
      end
      chk("same_cycle_new_pc", 32'(instr_pc), 32'h080);

      // PC wrap 0x1FF -> 0x000
      redirect = 1'b1;
      redirect_pc = 9'h1FE;
      cycle();
      chk("wrap_addr_1fe", 32'(imem_addr), 32'h1FE);
      cycle();
      chk("wrap_addr_1ff", 32'(imem_addr), 32'h1FF);
      cycle();
      chk("wrap_addr_000", 32'(imem_addr), 32'h000);

      // Randomized traffic against the stream model
      pops = popped.size();
      for (int i = 0; i < 600; i++) begin
         stall       = ($urandom_range(0, 99) < 30);
         lat_sel     = $urandom_range(0, 3);
         redirect    = ($urandom_range(0, 99) < 5);
         redirect_pc = 9'($urandom);
         cycle();
      end
      chk("random_progress", 32'((popped.size() - pops) > 40), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
